audio_serializer: RTL and testbench
===================================

AUDIO_SERIALIZER -- requirements
Module: audio_serializer

Interface
REQ-001 SHALL have parameter: BCLK_DIV, 4, clock cycles per bclk half-period (legal range 2..255).
REQ-002 SHALL have port: clock  in  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: l_audio_in  in  18  left sample, two's complement.
REQ-005 SHALL have port: r_audio_in  in  18  right sample, two's complement.
REQ-006 SHALL have port: ready  in  1  one-cycle strobe; the sample pair on l_audio_in/r_audio_in is valid.
REQ-007 SHALL have port: enable  in  1  level; run the serial output.
REQ-008 SHALL have port: bclk  out  1  serial bit clock.
REQ-009 SHALL have port: lrclk  out  1  word select; 0 = left slot, 1 = right slot.
REQ-010 SHALL have port: sdata  out  1  serial data, I2S format.
REQ-011 SHALL have port: frame_start  out  1  one-cycle pulse at each frame load.
REQ-012 SHALL have port: underrun  out  1  one-cycle pulse; a frame loaded with no new sample.
REQ-013 SHALL have port: overrun  out  1  one-cycle pulse; an unconsumed sample was overwritten.
REQ-014 SHALL have port: busy  out  1  high while in RUN.

Function
REQ-015 SHALL register all outputs.
REQ-016 SHALL implement two states: IDLE and RUN.
REQ-017 SHALL behave as follows in IDLE: bclk=0, lrclk=0, sdata=0, div and bit counters held at 0.
REQ-018 SHALL go from IDLE to RUN on the first cycle enable=1, and on that same edge perform a frame load with bit_cnt=0.
REQ-019 SHALL keep an 18+18-bit holding register plus a valid flag, loaded from the inputs on every cycle ready=1.
REQ-020 SHALL, on a frame load, copy holding to the shift registers, clear valid, and pulse frame_start.
REQ-021 SHALL, on a frame load with valid=0, load zeros into the shift registers and pulse underrun in the same cycle.
REQ-022 SHALL, when ready=1 and valid=1 and no frame load occurs that cycle, overwrite holding, keep valid=1, and pulse overrun.
REQ-023 SHALL, when ready=1 and a frame load occur in the same cycle, load the old holding contents, capture the new sample into holding, set valid=1, and not pulse overrun.
REQ-024 SHALL, in RUN, count div_cnt from 0 to BCLK_DIV-1, then wrap to 0 and toggle bclk; the bclk period is 2*BCLK_DIV clocks.
REQ-025 SHALL treat the cycle in which bclk toggles 1->0 as a bit step.
REQ-026 SHALL, on each bit step, increment bit_cnt modulo 64; a 63->0 wrap is a frame load.
REQ-027 SHALL set lrclk to bit_cnt[5] after each bit step, so each slot is 32 bclk long.
REQ-028 SHALL, for slot position p=bit_cnt[4:0], drive sdata = sample bit (18-p) for p=1..18 (MSB at p=1, one bclk after the lrclk change); sdata=0 for p=0 and p=19..31.
REQ-029 SHALL take the left sample in slot 0 and the right sample in slot 1.
REQ-030 SHALL, when enable falls during RUN, finish the current frame and enter IDLE on the 63->0 bit step instead of loading; no frame_start or underrun pulse on that step.
REQ-031 SHALL continue to accept ready in IDLE; REQ-022 applies there.
REQ-032 SHALL produce sdata and lrclk transitions only in cycles where bclk falls, or on IDLE->RUN entry.

Reset
REQ-033 SHALL, on reset=1, immediately force: state IDLE; bclk, lrclk, sdata, frame_start, underrun, overrun, busy = 0; counters 0; holding 0; valid 0.
REQ-034 SHALL, on reset asserted mid-frame, discard the partial frame; the first frame after release is a fresh load per REQ-018.

Verification
REQ-035 SHALL cover: BCLK_DIV=2, ready with L=18'h2AAAA R=18'h15555, then enable=1 -> frame_start in the entry cycle; bclk period 4 clocks; left slot sdata = 0,1,0,1,...,0 (18 bits) then 13 zeros; lrclk rises after bit step 32; right slot 0,0,1,0,1,...
REQ-036 SHALL cover: no ready before the second frame -> underrun pulse at the 63->0 wrap; the second frame is all-zero sdata.
REQ-037 SHALL cover: two ready strobes 10 cycles apart mid-frame -> one overrun pulse; the next frame carries the second sample.
REQ-038 SHALL cover: ready coincident with a frame load -> the old sample is transmitted, no overrun, and the new sample is sent in the following frame with no underrun.
REQ-039 SHALL cover: enable dropped at bit_cnt=10 -> the frame completes to bit 63, then IDLE with busy=0, bclk=0, and no extra frame_start.
REQ-040 SHALL cover: reset pulse at bit_cnt=40 -> all outputs 0 in the same cycle, asynchronously; after release with enable=1, a new frame starts at bit_cnt=0 with underrun (valid cleared).

Source files
------------

// File: rtl/audio_serializer.sv
// audio_serializer
//   Serializes 18-bit stereo sample pairs into a 64-bit I2S frame
//   (two 32-bclk slots, MSB one bclk after the lrclk change, the rest of
//   the slot padded with zeros). A single-entry holding register sits between
//   the sample source and the frame shift registers, so a sample may arrive
//   at any point in the frame before the one that carries it.
//
// Parameters
//   BCLK_DIV     system clocks per bclk half-period (2..255)
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   l_audio_in   left sample (two's complement)
//   r_audio_in   right sample (two's complement)
//   ready        one-cycle strobe, sample pair valid
//   enable       level, run the serial output
//   bclk         serial bit clock
//   lrclk        word select, 0 = left slot, 1 = right slot
//   sdata        serial data
//   frame_start  pulse at each frame load
//   underrun     pulse when a frame loads with no new sample
//   overrun      pulse when an unconsumed sample is overwritten
//   busy         high while running
module audio_serializer #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [17:0] l_audio_in,
    input  logic [17:0] r_audio_in,
    input  logic        ready,
    input  logic        enable,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        frame_start,
    output logic        underrun,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic        bclk_q, bclk_d;
    logic        lrclk_q, lrclk_d;
    logic        sdata_q, sdata_d;
    logic        fs_q, fs_d;
    logic        ur_q, ur_d;
    logic        ov_q, ov_d;
    logic        busy_q, busy_d;
    logic [17:0] hold_l_q, hold_l_d;
    logic [17:0] hold_r_q, hold_r_d;
    logic        valid_q, valid_d;
    logic [17:0] shl_q, shl_d;
    logic [17:0] shr_q, shr_d;
    logic        load;

    // Data for the bit position that the next bit step moves to.
    // Slot position p carries sample bit (18-p) for p = 1..18.
    logic [5:0] bit_inc;
    logic [4:0] pos;
    logic [4:0] sidx;
    logic       in_field;
    logic       slot_bit;

    assign bit_inc  = bit_q + 6'd1;
    assign pos      = bit_inc[4:0];
    assign sidx     = 5'd18 - pos;
    assign in_field = (pos != 5'd0) && (pos <= 5'd18);
    assign slot_bit = in_field && (bit_inc[5] ? shr_q[sidx] : shl_q[sidx]);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        bclk_d   = bclk_q;
        lrclk_d  = lrclk_q;
        sdata_d  = sdata_q;
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        valid_d  = valid_q;
        shl_d    = shl_q;
        shr_d    = shr_q;
        fs_d     = 1'b0;
        ur_d     = 1'b0;
        ov_d     = 1'b0;
        load     = 1'b0;

        case (state_q)
            IDLE: begin
                div_d   = '0;
                bit_d   = '0;
                bclk_d  = 1'b0;
                lrclk_d = 1'b0;
                sdata_d = 1'b0;
                if (enable) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    bclk_d = ~bclk_q;
                    // bclk falling edge: advance one bit
                    if (bclk_q) begin
                        bit_d   = bit_inc;
                        lrclk_d = bit_inc[5];
                        sdata_d = slot_bit;
                        if (bit_q == 6'd63) begin
                            if (enable) load = 1'b1;
                            else        state_d = IDLE;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shl_d   = valid_q ? hold_l_q : '0;
            shr_d   = valid_q ? hold_r_q : '0;
            ur_d    = ~valid_q;
            fs_d    = 1'b1;
            valid_d = 1'b0;
        end

        // A strobe coincident with a load refills holding after the old
        // contents have been taken, so it is not an overrun.
        if (ready) begin
            hold_l_d = l_audio_in;
            hold_r_d = r_audio_in;
            valid_d  = 1'b1;
            ov_d     = valid_q & ~load;
        end
    end

    assign busy_d = (state_d == RUN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            sdata_q  <= 1'b0;
            fs_q     <= 1'b0;
            ur_q     <= 1'b0;
            ov_q     <= 1'b0;
            busy_q   <= 1'b0;
            hold_l_q <= '0;
            hold_r_q <= '0;
            valid_q  <= 1'b0;
            shl_q    <= '0;
            shr_q    <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            bclk_q   <= bclk_d;
            lrclk_q  <= lrclk_d;
            sdata_q  <= sdata_d;
            fs_q     <= fs_d;
            ur_q     <= ur_d;
            ov_q     <= ov_d;
            busy_q   <= busy_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            valid_q  <= valid_d;
            shl_q    <= shl_d;
            shr_q    <= shr_d;
        end
    end

    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign sdata       = sdata_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;
    assign overrun     = ov_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_audio_serializer.sv
// tb_audio_serializer
//   Scoreboard bench for audio_serializer with BCLK_DIV = 2 (frame = 256
//   clocks). Tests push the frame they expect next; a monitor pops one entry
//   per frame_start and checks every bit, lrclk and underrun against it.
module tb_audio_serializer;

    localparam int DIV   = 2;
    localparam int FRAME = 64 * 2 * DIV;

    typedef struct packed {
        logic [17:0] l;
        logic [17:0] r;
        logic        uf;
    } frame_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] l_audio_in = '0;
    logic [17:0] r_audio_in = '0;
    logic        ready = 1'b0;
    logic        enable = 1'b0;
    logic        bclk, lrclk, sdata, frame_start, underrun, overrun, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int ov_cnt   = 0;
    int fs_cnt   = 0;

    frame_t exp_q[$];

    audio_serializer #(.BCLK_DIV(DIV)) dut (
        .clock       (clock),
        .reset       (reset),
        .l_audio_in  (l_audio_in),
        .r_audio_in  (r_audio_in),
        .ready       (ready),
        .enable      (enable),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .frame_start (frame_start),
        .underrun    (underrun),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    function automatic frame_t mk(input logic [17:0] l, input logic [17:0] r, input logic uf);
        frame_t f;
        f.l  = l;
        f.r  = r;
        f.uf = uf;
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic strobe(input logic [17:0] l, input logic [17:0] r);
        l_audio_in = l;
        r_audio_in = r;
        ready      = 1'b1;
        @(negedge clock);
        ready      = 1'b0;
    endtask

    task automatic wait_fs(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            if (frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Monitor: per-bit scoreboard plus alignment of sdata/lrclk changes.
    initial begin
        frame_t cur;
        bit     have_cur;
        int     pos;
        logic   prev_bclk, prev_sdata, prev_lrclk, fell, eb;
        logic [17:0] smp;
        int     p;
        have_cur   = 1'b0;
        pos        = 0;
        cur        = '0;
        prev_bclk  = 1'b0;
        prev_sdata = 1'b0;
        prev_lrclk = 1'b0;
        forever begin
            @(negedge clock);
            if (overrun === 1'b1)     ov_cnt++;
            if (frame_start === 1'b1) fs_cnt++;
            if (reset) begin
                have_cur = 1'b0;
            end else begin
                fell = prev_bclk && !bclk;
                if (sdata !== prev_sdata || lrclk !== prev_lrclk) begin
                    n_checks++;
                    if (!(fell || frame_start)) begin
                        n_fail++;
                        $display("FAIL edge_align t=%0t sdata=%b lrclk=%b changed without bclk fall", $time, sdata, lrclk);
                    end
                end
                if (frame_start === 1'b1) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        have_cur = 1'b0;
                        $display("FAIL frame_unexpected t=%0t got frame_start, expected none", $time);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        pos      = 0;
                        if (underrun !== cur.uf) begin
                            n_fail++;
                            $display("FAIL frame_underrun t=%0t got %b expected %b", $time, underrun, cur.uf);
                        end
                        n_checks++;
                        if (sdata !== 1'b0 || lrclk !== 1'b0) begin
                            n_fail++;
                            $display("FAIL frame_p0 t=%0t got sdata=%b lrclk=%b expected 0 0", $time, sdata, lrclk);
                        end
                    end
                end else if (fell && busy === 1'b1 && have_cur) begin
                    pos++;
                    p   = pos % 32;
                    smp = (pos >= 32) ? cur.r : cur.l;
                    eb  = (p >= 1 && p <= 18) ? smp[18 - p] : 1'b0;
                    n_checks++;
                    if (sdata !== eb || lrclk !== (pos >= 32)) begin
                        n_fail++;
                        $display("FAIL bit%0d t=%0t got sdata=%b lrclk=%b expected %b %b",
                                 pos, $time, sdata, lrclk, eb, (pos >= 32));
                    end
                end
            end
            prev_bclk  = bclk;
            prev_sdata = sdata;
            prev_lrclk = lrclk;
        end
    end

    task automatic test_reset;
        tick(2);
        n_checks++; if (bclk !== 1'b0)        begin n_fail++; $display("FAIL rst_bclk got %b expected 0", bclk); end
        n_checks++; if (lrclk !== 1'b0)       begin n_fail++; $display("FAIL rst_lrclk got %b expected 0", lrclk); end
        n_checks++; if (sdata !== 1'b0)       begin n_fail++; $display("FAIL rst_sdata got %b expected 0", sdata); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_fs got %b expected 0", frame_start); end
        n_checks++; if (underrun !== 1'b0)    begin n_fail++; $display("FAIL rst_ur got %b expected 0", underrun); end
        n_checks++; if (overrun !== 1'b0)     begin n_fail++; $display("FAIL rst_ov got %b expected 0", overrun); end
        n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy got %b expected 0", busy); end
        reset = 1'b0;
        tick(3);
        n_checks++;
        if (busy !== 1'b0 || bclk !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold got busy=%b bclk=%b expected 0 0", busy, bclk);
        end
    endtask

    task automatic test_basic;
        int c;
        strobe(18'h2AAAA, 18'h15555);
        exp_q.push_back(mk(18'h2AAAA, 18'h15555, 1'b0));
        enable = 1'b1;
        @(negedge clock);
        n_checks++;
        if (frame_start !== 1'b1 || busy !== 1'b1 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL entry_load got fs=%b busy=%b ur=%b expected 1 1 0", frame_start, busy, underrun);
        end
        // bclk rises DIV clocks after entry, falls DIV later, rises again DIV later
        c = 0;
        while (bclk !== 1'b1 && c < 20) begin @(negedge clock); c++; end
        n_checks++; if (c !== DIV) begin n_fail++; $display("FAIL bclk_first_rise got %0d expected %0d", c, DIV); end
        c = 0;
        while (bclk !== 1'b0 && c < 20) begin @(negedge clock); c++; end
        while (bclk !== 1'b1 && c < 20) begin @(negedge clock); c++; end
        n_checks++; if (c !== 2 * DIV) begin n_fail++; $display("FAIL bclk_period got %0d expected %0d", c, 2 * DIV); end
    endtask

    task automatic test_underrun;
        bit found;
        exp_q.push_back(mk(18'h0, 18'h0, 1'b1));
        wait_fs(FRAME + 10, found);
        n_checks++;
        if (!found || underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_wrap got found=%b ur=%b expected 1 1", found, underrun);
        end
    endtask

    task automatic test_overrun;
        bit found;
        int ov0;
        tick(20);
        ov0 = ov_cnt;
        strobe(18'h3F00F, 18'h00FF0);
        tick(9);
        strobe(18'h12345, 18'h2BCDE);
        exp_q.push_back(mk(18'h12345, 18'h2BCDE, 1'b0));
        wait_fs(FRAME, found);
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL overrun_frame got no frame_start expected one"); end
        n_checks++;
        if (ov_cnt - ov0 !== 1) begin
            n_fail++;
            $display("FAIL overrun_count got %0d expected 1", ov_cnt - ov0);
        end
    endtask

    // Entered at the negedge after a load edge; the next load edge is FRAME later.
    task automatic test_coincident;
        bit found;
        int ov0;
        int c;
        c = 0;
        tick(30); c += 30;
        strobe(18'h1F0F0, 18'h0A5A5); c += 1;
        exp_q.push_back(mk(18'h1F0F0, 18'h0A5A5, 1'b0));
        tick(FRAME - 1 - c);
        ov0 = ov_cnt;
        l_audio_in = 18'h30C3C;
        r_audio_in = 18'h05A5A;
        ready      = 1'b1;
        exp_q.push_back(mk(18'h30C3C, 18'h05A5A, 1'b0));
        @(negedge clock);
        ready = 1'b0;
        n_checks++;
        if (frame_start !== 1'b1 || overrun !== 1'b0 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL coinc_load got fs=%b ov=%b ur=%b expected 1 0 0", frame_start, overrun, underrun);
        end
        wait_fs(FRAME + 10, found);
        n_checks++;
        if (!found || underrun !== 1'b0 || ov_cnt !== ov0) begin
            n_fail++;
            $display("FAIL coinc_next got found=%b ur=%b ov=%0d expected 1 0 0", found, underrun, ov_cnt - ov0);
        end
    endtask

    task automatic test_enable_drop;
        int c;
        int fs0;
        tick(41);
        c = 41;
        enable = 1'b0;
        fs0 = fs_cnt;
        while (busy === 1'b1 && c < FRAME + 40) begin @(negedge clock); c++; end
        n_checks++;
        if (c !== FRAME) begin n_fail++; $display("FAIL drop_idle_time got %0d expected %0d", c, FRAME); end
        n_checks++;
        if (bclk !== 1'b0 || lrclk !== 1'b0 || sdata !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_idle_out got bclk=%b lrclk=%b sdata=%b expected 0 0 0", bclk, lrclk, sdata);
        end
        tick(10);
        n_checks++;
        if (busy !== 1'b0 || fs_cnt !== fs0) begin
            n_fail++;
            $display("FAIL drop_no_frame got busy=%b extra_fs=%0d expected 0 0", busy, fs_cnt - fs0);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL drop_queue got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        int c;
        strobe(18'h3FFFF, 18'h20001);
        exp_q.push_back(mk(18'h3FFFF, 18'h20001, 1'b0));
        enable = 1'b1;
        @(negedge clock);
        n_checks++;
        if (frame_start !== 1'b1) begin n_fail++; $display("FAIL rm_entry got fs=%b expected 1", frame_start); end
        tick(160);
        n_checks++;
        if (lrclk !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_bit40 got lrclk=%b busy=%b expected 1 1", lrclk, busy);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({bclk, lrclk, sdata, frame_start, underrun, overrun, busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL rm_async got %b expected 0000000",
                     {bclk, lrclk, sdata, frame_start, underrun, overrun, busy});
        end
        exp_q.push_back(mk(18'h0, 18'h0, 1'b1));
        tick(2);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (frame_start !== 1'b1 || underrun !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_restart got fs=%b ur=%b busy=%b expected 1 1 1", frame_start, underrun, busy);
        end
        tick(100);
        enable = 1'b0;
        c = 0;
        while (busy === 1'b1 && c < FRAME + 20) begin @(negedge clock); c++; end
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL rm_end got busy=%b queue=%0d expected 0 0", busy, exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_overrun();
        test_coincident();
        test_enable_drop();
        test_reset_mid();
        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
